// File: rtl/corr_pkg.sv
// corr_pkg: shared widths, Q1.15 output limits and states
// for the dual-antenna correlation accumulator.
package corr_pkg;

  typedef enum logic {
    WAIT_SYNC,
    RUN
  } state_t;

  localparam int Q_FRAC = 15;

  localparam logic [15:0] U_SAT   = 16'hFFFF;
  localparam logic [15:0] S_SAT_P = 16'h7FFF;
  localparam logic [15:0] S_SAT_N = 16'h8000;

  function automatic int prod_w(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int acc_w(input int dw, input int al);
    return 2 * dw + 1 + al;
  endfunction

  // LSBs dropped going from point 2*dw-2 down to Q1.15
  function automatic int drop_w(input int dw);
    return 2 * dw - 2 - Q_FRAC;
  endfunction

endpackage

// File: rtl/corr_mac.sv
// corr_mac: two-stage multiplier pipeline forming the
// full-precision powers |A|^2, |B|^2 and Re(A*conj(B)).
module corr_mac
  import corr_pkg::*;
#(
  parameter int DIN_WIDTH = 18
) (
  input  logic                                clk,
  input  logic signed [DIN_WIDTH-1:0]         a_re,
  input  logic signed [DIN_WIDTH-1:0]         a_im,
  input  logic signed [DIN_WIDTH-1:0]         b_re,
  input  logic signed [DIN_WIDTH-1:0]         b_im,
  output logic signed [prod_w(DIN_WIDTH)-1:0] p11,
  output logic signed [prod_w(DIN_WIDTH)-1:0] p22,
  output logic signed [prod_w(DIN_WIDTH)-1:0] p12
);

  localparam int MW = 2 * DIN_WIDTH;
  localparam int PW = prod_w(DIN_WIDTH);

  typedef logic signed [MW-1:0] m_t;
  typedef logic signed [PW-1:0] p_t;

  m_t arr_d, aii_d, brr_d, bii_d, abr_d, abi_d;
  m_t arr_q, aii_q, brr_q, bii_q, abr_q, abi_q;
  p_t p11_d, p22_d, p12_d;
  p_t p11_q, p22_q, p12_q;

  function automatic m_t mul(
    input logic signed [DIN_WIDTH-1:0] x,
    input logic signed [DIN_WIDTH-1:0] y
  );
    return m_t'(x) * m_t'(y);
  endfunction

  always_comb begin
    arr_d = mul(a_re, a_re);
    aii_d = mul(a_im, a_im);
    brr_d = mul(b_re, b_re);
    bii_d = mul(b_im, b_im);
    abr_d = mul(a_re, b_re);
    abi_d = mul(a_im, b_im);
  end

  always_comb begin
    p11_d = PW'(arr_q) + PW'(aii_q);
    p22_d = PW'(brr_q) + PW'(bii_q);
    p12_d = PW'(abr_q) + PW'(abi_q);
  end

  always_ff @(posedge clk) begin
    arr_q <= arr_d;
    aii_q <= aii_d;
    brr_q <= brr_d;
    bii_q <= bii_d;
    abr_q <= abr_d;
    abi_q <= abi_d;
    p11_q <= p11_d;
    p22_q <= p22_d;
    p12_q <= p12_d;
  end

  assign p11 = p11_q;
  assign p22 = p22_q;
  assign p12 = p12_q;

endmodule

// File: rtl/corr_acc.sv
// corr_acc: per-channel averaging of |A|^2, |B|^2 and
// Re(A*conj(B)) over 2^ACC_LEN_LOG2 spectra, Q1.15 output.
module corr_acc
  import corr_pkg::*;
#(
  parameter int DIN_WIDTH    = 18,
  parameter int VEC_LEN      = 512,
  parameter int ACC_LEN_LOG2 = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync_in,
  input  logic                        din_valid,
  input  logic signed [DIN_WIDTH-1:0] a_re,
  input  logic signed [DIN_WIDTH-1:0] a_im,
  input  logic signed [DIN_WIDTH-1:0] b_re,
  input  logic signed [DIN_WIDTH-1:0] b_im,
  output logic [15:0]                 r11,
  output logic [15:0]                 r22,
  output logic [15:0]                 r12,
  output logic [$clog2(VEC_LEN)-1:0]  chan,
  output logic                        dout_valid
);

  localparam int CW = $clog2(VEC_LEN);
  localparam int SW = (ACC_LEN_LOG2 > 0) ? ACC_LEN_LOG2 : 1;
  localparam int PW = prod_w(DIN_WIDTH);
  localparam int AW = acc_w(DIN_WIDTH, ACC_LEN_LOG2);
  localparam int SH = ACC_LEN_LOG2 + drop_w(DIN_WIDTH);

  localparam logic [SW-1:0] SP_LAST = SW'((1 << ACC_LEN_LOG2) - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(VEC_LEN - 1);

  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t LIM_U = AW'(65535);
  localparam acc_t LIM_P = AW'(32767);
  localparam acc_t LIM_N = AW'(-32768);

  state_t        state_q, state_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [SW-1:0] sp_cnt_q, sp_cnt_d;
  logic          take;
  logic [CW-1:0] ch_in;
  logic [SW-1:0] sp_in;

  logic signed [DIN_WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
  logic signed [PW-1:0]        p11, p22, p12;

  logic          v0_q, v1_q, v2_q, v3_q;
  logic          f0_q, f1_q, f2_q;
  logic          l0_q, l1_q, l2_q;
  logic [CW-1:0] c0_q, c1_q, c2_q, c3_q;

  logic [3*AW-1:0] ram [VEC_LEN];
  logic [3*AW-1:0] old_q;
  acc_t            o11, o22, o12;
  acc_t            n11_d, n22_d, n12_d;
  acc_t            a11_q, a22_q, a12_q;
  acc_t            s11, s22, s12;

  logic [15:0]   r11_d, r22_d, r12_d;
  logic [15:0]   r11_q, r22_q, r12_q;
  logic [CW-1:0] chan_q;
  logic          dv_q;

  // A sync beat always restarts at channel 0 / spectrum 0
  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    sp_cnt_d = sp_cnt_q;
    take     = 1'b0;
    ch_in    = ch_cnt_q;
    sp_in    = sp_cnt_q;
    unique case (1'b1)
      din_valid && sync_in: begin
        take    = 1'b1;
        ch_in   = '0;
        sp_in   = '0;
        state_d = RUN;
      end
      din_valid && !sync_in && state_q == RUN: begin
        take = 1'b1;
      end
      default: ;
    endcase
    if (take) begin
      ch_cnt_d = ch_in + CW'(1);
      sp_cnt_d = sp_in;
      if (ch_in == CH_LAST) begin
        sp_cnt_d = (sp_in == SP_LAST) ? '0 : sp_in + SW'(1);
      end
    end
  end

  corr_mac #(
    .DIN_WIDTH(DIN_WIDTH)
  ) u_mac (
    .clk (clk),
    .a_re(ar_q),
    .a_im(ai_q),
    .b_re(br_q),
    .b_im(bi_q),
    .p11 (p11),
    .p22 (p22),
    .p12 (p12)
  );

  assign o11 = old_q[3*AW-1 -: AW];
  assign o22 = old_q[2*AW-1 -: AW];
  assign o12 = old_q[AW-1 -: AW];

  always_comb begin
    n11_d = AW'(p11);
    n22_d = AW'(p22);
    n12_d = AW'(p12);
    if (!f2_q) begin
      n11_d = o11 + AW'(p11);
      n22_d = o22 + AW'(p22);
      n12_d = o12 + AW'(p12);
    end
  end

  always_comb begin
    s11   = a11_q >>> SH;
    s22   = a22_q >>> SH;
    s12   = a12_q >>> SH;
    r11_d = (s11 > LIM_U) ? U_SAT : s11[15:0];
    r22_d = (s22 > LIM_U) ? U_SAT : s22[15:0];
    unique case (1'b1)
      s12 > LIM_P: r12_d = S_SAT_P;
      s12 < LIM_N: r12_d = S_SAT_N;
      default:     r12_d = s12[15:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_SYNC;
      ch_cnt_q <= '0;
      sp_cnt_q <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      dv_q     <= 1'b0;
      r11_q    <= '0;
      r22_q    <= '0;
      r12_q    <= '0;
      chan_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      sp_cnt_q <= sp_cnt_d;
      v0_q     <= take;
      v1_q     <= v0_q;
      v2_q     <= v1_q;
      v3_q     <= v2_q & l2_q;
      dv_q     <= v3_q;
      if (v3_q) begin
        r11_q  <= r11_d;
        r22_q  <= r22_d;
        r12_q  <= r12_d;
        chan_q <= c3_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    ar_q  <= a_re;
    ai_q  <= a_im;
    br_q  <= b_re;
    bi_q  <= b_im;
    c0_q  <= ch_in;
    f0_q  <= (sp_in == '0);
    l0_q  <= (sp_in == SP_LAST);
    c1_q  <= c0_q;
    f1_q  <= f0_q;
    l1_q  <= l0_q;
    c2_q  <= c1_q;
    f2_q  <= f1_q;
    l2_q  <= l1_q;
    old_q <= ram[c1_q];
    c3_q  <= c2_q;
    a11_q <= n11_d;
    a22_q <= n22_d;
    a12_q <= n12_d;
  end

  always_ff @(posedge clk) begin
    if (v2_q) begin
      ram[c2_q] <= {n11_d, n22_d, n12_d};
    end
  end

  assign r11        = r11_q;
  assign r22        = r22_q;
  assign r12        = r12_q;
  assign chan       = chan_q;
  assign dout_valid = dv_q;

endmodule

// File: tb/tb_corr_acc.sv
// tb_corr_acc: scoreboard bench for corr_acc with a
// per-channel integer model of the averaged outputs.
module tb_corr_acc;

  localparam int DW  = 18;
  localparam int VL  = 8;
  localparam int AL  = 2;
  localparam int NSP = 1 << AL;
  localparam int SH  = AL + 2 * DW - 17;
  localparam int LAT = 4;

  typedef logic signed [DW-1:0] d_t;

  localparam d_t HALF  = d_t'(1 << (DW - 2));
  localparam d_t NHALF = d_t'(-(1 << (DW - 2)));
  localparam d_t NEG1  = d_t'(1 << (DW - 1));
  localparam d_t ZERO  = d_t'(0);

  typedef struct {
    int          cyc;
    logic [2:0]  ch;
    logic [15:0] r11;
    logic [15:0] r22;
    logic [15:0] r12;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync_in = 1'b0;
  logic        din_valid = 1'b0;
  d_t          a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [15:0] r11, r22, r12;
  logic [2:0]  chan;
  logic        dout_valid;

  corr_acc #(
    .DIN_WIDTH   (DW),
    .VEC_LEN     (VL),
    .ACC_LEN_LOG2(AL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (sync_in),
    .din_valid (din_valid),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .r11       (r11),
    .r22       (r22),
    .r12       (r12),
    .chan      (chan),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        sb[$];
  logic [50:0] obs[$];
  logic [50:0] obs_a[$];
  exp_t        mon_e;

  bit     m_run = 0;
  int     m_ch  = 0;
  int     m_sp  = 0;
  longint m11[VL], m22[VL], m12[VL];

  d_t rar[32], rai[32], rbr[32], rbi[32];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat_u(input longint s);
    longint v;
    v = s >>> SH;
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [15:0] sat_s(input longint s);
    longint v;
    v = s >>> SH;
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic model(input bit s, input d_t ar, input d_t ai,
                       input d_t br, input d_t bi);
    longint p11, p22, p12;
    exp_t   e;
    if (s) begin
      m_run = 1;
      m_ch  = 0;
      m_sp  = 0;
    end else if (!m_run) begin
      return;
    end
    p11 = longint'(ar) * longint'(ar) + longint'(ai) * longint'(ai);
    p22 = longint'(br) * longint'(br) + longint'(bi) * longint'(bi);
    p12 = longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
    if (m_sp == 0) begin
      m11[m_ch] = p11;
      m22[m_ch] = p22;
      m12[m_ch] = p12;
    end else begin
      m11[m_ch] += p11;
      m22[m_ch] += p22;
      m12[m_ch] += p12;
    end
    if (m_sp == NSP - 1) begin
      e.cyc = cyc + 1 + LAT;
      e.ch  = 3'(m_ch);
      e.r11 = sat_u(m11[m_ch]);
      e.r22 = sat_u(m22[m_ch]);
      e.r12 = sat_s(m12[m_ch]);
      sb.push_back(e);
    end
    m_ch++;
    if (m_ch == VL) begin
      m_ch = 0;
      m_sp = (m_sp + 1) % NSP;
    end
  endtask

  task automatic beat(input bit s, input d_t ar, input d_t ai,
                      input d_t br, input d_t bi);
    @(negedge clk);
    sync_in   = s;
    din_valid = 1'b1;
    a_re      = ar;
    a_im      = ai;
    b_re      = br;
    b_im      = bi;
    model(s, ar, ai, br, bi);
  endtask

  task automatic idle(input int n, input bit s = 1'b0);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      sync_in   = s;
    end
  endtask

  task automatic gap();
    int k = 0;
    while (k < 20 && $urandom_range(0, 99) >= 30) begin
      idle(1, 1'($urandom_range(0, 1)));
      k++;
    end
  endtask

  task automatic frame_const(input d_t ar, input d_t ai, input d_t br,
                             input d_t bi, input int n);
    for (int i = 0; i < n; i++) beat(i == 0, ar, ai, br, bi);
  endtask

  task automatic frame_arr(input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps) gap();
      beat(i == 0, rar[i], rai[i], rbr[i], rbi[i]);
    end
  endtask

  task automatic drain(input string tag);
    idle(12);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_lit(input string tag, input logic [15:0] e11,
                         input logic [15:0] e22, input logic [15:0] e12);
    logic [50:0] o;
    chk({tag, "_nout"}, obs.size(), VL);
    if (obs.size() > 0) begin
      o = obs[0];
      chk({tag, "_chan0"}, o[50:48], 0);
      o = obs[obs.size() - 1];
      chk({tag, "_chan7"}, o[50:48], VL - 1);
      chk({tag, "_r11"}, o[47:32], e11);
      chk({tag, "_r22"}, o[31:16], e22);
      chk({tag, "_r12"}, o[15:0], e12);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst       = 1'b1;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    m_run     = 0;
    sb.delete();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    chk("rst_dv", dout_valid, 0);
    chk("rst_chan", chan, 0);
    chk("rst_r11", r11, 0);
    chk("rst_r22", r22, 0);
    chk("rst_r12", r12, 0);
  endtask

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      obs.push_back({chan, r11, r22, r12});
      if (sb.size() == 0) begin
        chk("spurious_dout", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("chan", chan, mon_e.ch);
        chk("r11", r11, mon_e.r11);
        chk("r22", r22, mon_e.r22);
        chk("r12", r12, mon_e.r12);
        chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rar[i] = d_t'($urandom());
      rai[i] = d_t'($urandom());
      rbr[i] = d_t'($urandom());
      rbi[i] = d_t'($urandom());
    end

    do_reset(4);

    obs.delete();
    frame_const(HALF, ZERO, HALF, ZERO, 32);
    drain("t1");
    chk_lit("t1", 16'h2000, 16'h2000, 16'h2000);

    obs.delete();
    frame_const(HALF, ZERO, ZERO, HALF, 32);
    drain("t2");
    chk_lit("t2", 16'h2000, 16'h2000, 16'h0000);

    obs.delete();
    frame_const(HALF, ZERO, NHALF, ZERO, 32);
    drain("t3");
    chk_lit("t3", 16'h2000, 16'h2000, 16'hE000);

    obs.delete();
    frame_const(NEG1, NEG1, NEG1, ZERO, 32);
    drain("t4");
    chk_lit("t4", 16'hFFFF, 16'h8000, 16'h7FFF);

    obs.delete();
    frame_arr(1'b0);
    drain("t5a");
    obs_a = obs;
    obs.delete();
    frame_arr(1'b1);
    drain("t5b");
    chk("t5_count", obs.size(), obs_a.size());
    for (int i = 0; i < obs.size() && i < obs_a.size(); i++) begin
      chk("t5_same_ch", 32'(obs[i][50:48]), 32'(obs_a[i][50:48]));
      chk("t5_same_r12", 32'(obs[i][15:0]), 32'(obs_a[i][15:0]));
    end

    obs.delete();
    frame_const(NEG1, NEG1, NEG1, NEG1, VL + 3);
    frame_const(HALF, ZERO, HALF, ZERO, 32);
    drain("t6");
    chk_lit("t6", 16'h2000, 16'h2000, 16'h2000);

    obs.delete();
    frame_const(HALF, ZERO, NHALF, ZERO, 3 * VL + 5);
    do_reset(2);
    chk("t7_pre_rst_out", obs.size(), 1);
    for (int i = 0; i < 10; i++) beat(1'b0, NEG1, NEG1, NEG1, NEG1);
    idle(12);
    chk("t7_quiet", obs.size(), 1);
    obs.delete();
    frame_const(HALF, ZERO, ZERO, HALF, 32);
    drain("t7");
    chk_lit("t7", 16'h2000, 16'h2000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
